// File: rtl/uart_tx.sv
// uart_tx: serial UART transmitter, 8 data bits LSB first, optional parity bit,
// one stop bit. A frame is requested by a level on send; a held request sends
// exactly one frame, and send must drop before the next frame can start.
//
// Ports:
//   clk      system clock, all state updates on posedge
//   reset_n  asynchronous active-low reset
//   send     transmit request (level, synchronous to clk)
//   din      byte to send, captured when the request is accepted
//   tx_out   serial line, idles high (registered)
//   busy     high while a frame is on the line, START through STOP (registered)
//   done     one-cycle pulse on the last cycle of the stop bit (registered)
module uart_tx #(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD_RATE  = 19_200,
    parameter bit          PARITY_EN  = 1'b0,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       send,
    input  logic [7:0] din,
    output logic       tx_out,
    output logic       busy,
    output logic       done
);

    localparam int unsigned    BaudDiv = CLK_FREQ / BAUD_RATE;
    localparam int unsigned    CntW    = (BaudDiv > 1) ? $clog2(BaudDiv) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(BaudDiv - 1);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StStart   = 3'd1;
    localparam logic [2:0] StData    = 3'd2;
    localparam logic [2:0] StParity  = 3'd3;
    localparam logic [2:0] StStop    = 3'd4;
    localparam logic [2:0] StWaitLow = 3'd5;

    logic [2:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            tx_d, busy_d, done_d;
    logic            bit_tick;
    logic            in_frame;

    assign bit_tick = (cnt_q == CntMax);
    assign in_frame = (state_q == StStart) || (state_q == StData) ||
                      (state_q == StParity) || (state_q == StStop);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        // Timer runs only while a frame is on the line; wraps on the tick.
        if (in_frame) begin
            cnt_d = bit_tick ? '0 : cnt_q + 1'b1;
        end else begin
            cnt_d = '0;
        end

        case (state_q)
            StIdle: begin
                if (send) begin
                    state_d = StStart;
                    shift_d = din;
                    data_d  = din;
                end
            end
            StStart: begin
                if (bit_tick) begin
                    state_d = StData;
                    idx_d   = 3'd0;
                end
            end
            StData: begin
                if (bit_tick) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = PARITY_EN ? StParity : StStop;
                    end
                end
            end
            StParity: begin
                if (bit_tick) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                if (bit_tick) begin
                    state_d = StWaitLow;
                end
            end
            StWaitLow: begin
                // Held request is absorbed here so it cannot start a second frame.
                if (!send) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are registered from next-state values so they line up with the
    // state register: the line drops on the accepting edge itself.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        case (state_d)
            StStart: begin
                tx_d   = 1'b0;
                busy_d = 1'b1;
            end
            StData: begin
                tx_d   = shift_d[0];
                busy_d = 1'b1;
            end
            StParity: begin
                tx_d   = (^data_d) ^ PARITY_ODD;
                busy_d = 1'b1;
            end
            StStop: begin
                tx_d   = 1'b1;
                busy_d = 1'b1;
            end
            default: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
            end
        endcase
        done_d = (state_d == StStop) && (cnt_d == CntMax);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'd0;
            data_q  <= 8'd0;
            tx_out  <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            tx_out  <= tx_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: drives three transmitters (no parity, even parity, odd parity)
// with the same request/byte and checks every line bit, frame length, busy and
// done against hand-derived values. A short baud divisor (8) keeps runs small.
module tb_uart_tx;

    localparam int Div  = 8;
    localparam int MaxC = 12 * Div;

    logic       clk;
    logic       reset_n;
    logic       send;
    logic [7:0] din;
    logic [2:0] tx_v, busy_v, done_v;

    int checks = 0;
    int errors = 0;

    logic rec_tx [3][MaxC];
    int   busy_cnt [3];
    int   done_cnt [3];
    int   done_pos [3];

    uart_tx #(.CLK_FREQ(80), .BAUD_RATE(10), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .send(send), .din(din),
        .tx_out(tx_v[0]), .busy(busy_v[0]), .done(done_v[0])
    );
    uart_tx #(.CLK_FREQ(80), .BAUD_RATE(10), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .send(send), .din(din),
        .tx_out(tx_v[1]), .busy(busy_v[1]), .done(done_v[1])
    );
    uart_tx #(.CLK_FREQ(80), .BAUD_RATE(10), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .send(send), .din(din),
        .tx_out(tx_v[2]), .busy(busy_v[2]), .done(done_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Request a frame and record all three lines for MaxC cycles, sampled on
    // negedges starting with the cycle right after the accepting edge.
    task automatic run_frame(input logic [7:0] d, input int hold, input int chg,
                             input logic rel);
        @(negedge clk);
        din  = d;
        send = 1'b1;
        if (rel) reset_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            busy_cnt[k] = 0;
            done_cnt[k] = 0;
            done_pos[k] = -1;
        end
        for (int c = 0; c < MaxC; c++) begin
            for (int k = 0; k < 3; k++) begin
                rec_tx[k][c] = tx_v[k];
                if (busy_v[k] === 1'b1) busy_cnt[k]++;
                if (done_v[k] === 1'b1) begin
                    done_cnt[k]++;
                    done_pos[k] = c;
                end
            end
            if (c + 1 >= hold) send = 1'b0;
            if (c == chg) din = 8'h0F;
            @(negedge clk);
        end
    endtask

    task automatic check_frame(input string name, input logic [7:0] d,
                               input logic pe, input logic po);
        for (int k = 0; k < 3; k++) begin
            int nb;
            int bad;
            logic e;
            nb = (k == 0) ? 10 : 11;
            for (int b = 0; b < nb; b++) begin
                if (b == 0)                e = 1'b0;
                else if (b <= 8)           e = d[b-1];
                else if (b == 9 && k == 1) e = pe;
                else if (b == 9 && k == 2) e = po;
                else                       e = 1'b1;
                bad = 0;
                for (int c = b * Div; c < (b + 1) * Div; c++) begin
                    if (rec_tx[k][c] !== e) bad++;
                end
                chk($sformatf("%s dut%0d bit%0d wrong_samples", name, k, b), bad, 0);
            end
            bad = 0;
            for (int c = nb * Div; c < MaxC; c++) begin
                if (rec_tx[k][c] !== 1'b1) bad++;
            end
            chk($sformatf("%s dut%0d idle_after_wrong_samples", name, k), bad, 0);
            chk($sformatf("%s dut%0d busy_cycles", name, k), busy_cnt[k], nb * Div);
            chk($sformatf("%s dut%0d done_pulses", name, k), done_cnt[k], 1);
            chk($sformatf("%s dut%0d done_pos", name, k), done_pos[k], nb * Div - 1);
        end
    endtask

    typedef struct {
        logic [7:0] d;
        int         hold;
        int         chg;
        logic       pe;
        logic       po;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int bad_tx, bad_busy, bad_done;

        vecs[0] = '{d: 8'h55, hold: 1,   chg: -1,          pe: 1'b0, po: 1'b1};
        vecs[1] = '{d: 8'h07, hold: 1,   chg: -1,          pe: 1'b1, po: 1'b0};
        vecs[2] = '{d: 8'hA3, hold: 200, chg: -1,          pe: 1'b0, po: 1'b1};
        vecs[3] = '{d: 8'hA3, hold: 1,   chg: -1,          pe: 1'b0, po: 1'b1};
        vecs[4] = '{d: 8'hF0, hold: 1,   chg: 4 * Div + 2, pe: 1'b0, po: 1'b1};
        vecs[5] = '{d: 8'h00, hold: 1,   chg: -1,          pe: 1'b0, po: 1'b1};
        vecs[6] = '{d: 8'hFF, hold: 1,   chg: -1,          pe: 1'b0, po: 1'b1};
        vecs[7] = '{d: 8'h80, hold: 1,   chg: -1,          pe: 1'b1, po: 1'b0};

        // Reset and quiet idle.
        reset_n = 1'b0;
        send    = 1'b0;
        din     = 8'h00;
        repeat (3) @(negedge clk);
        chk("in_reset tx", tx_v, 3'b111);
        chk("in_reset busy", busy_v, 3'b000);
        chk("in_reset done", done_v, 3'b000);
        reset_n = 1'b1;
        bad_tx = 0; bad_busy = 0; bad_done = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (tx_v !== 3'b111) bad_tx++;
            if (busy_v !== 3'b000) bad_busy++;
            if (done_v !== 3'b000) bad_done++;
        end
        chk("idle tx_not_high_cycles", bad_tx, 0);
        chk("idle busy_cycles", bad_busy, 0);
        chk("idle done_cycles", bad_done, 0);

        for (int i = 0; i < 8; i++) begin
            run_frame(vecs[i].d, vecs[i].hold, vecs[i].chg, 1'b0);
            check_frame($sformatf("vec%0d", i), vecs[i].d, vecs[i].pe, vecs[i].po);
            if (send) begin
                // Request still held: no second start bit may appear.
                bad_tx = 0;
                for (int c = 0; c < 100; c++) begin
                    if (tx_v !== 3'b111 || busy_v !== 3'b000) bad_tx++;
                    @(negedge clk);
                end
                chk("held_send second_frame_cycles", bad_tx, 0);
                send = 1'b0;
            end
            repeat (3) @(negedge clk);
        end

        // Reset in the middle of data bit 4 (line bit 5) of an all-zero byte.
        @(negedge clk);
        din  = 8'h00;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        repeat (5 * Div + 3) @(negedge clk);
        chk("pre_reset line", tx_v, 3'b000);
        chk("pre_reset busy", busy_v, 3'b111);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset tx", tx_v, 3'b111);
        chk("async_reset busy", busy_v, 3'b000);
        chk("async_reset done", done_v, 3'b000);
        bad_done = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (done_v !== 3'b000 || tx_v !== 3'b111) bad_done++;
        end
        chk("held_reset bad_cycles", bad_done, 0);
        run_frame(8'hC5, 1, -1, 1'b1);
        check_frame("after_reset", 8'hC5, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
